// File: rtl/derm_inbuf_pkg.sv
// rtl/derm_inbuf_pkg.sv - shared widths, read FSM states and lane extraction for the input buffer reader
package derm_inbuf_pkg;

  localparam int DATA_W   = 36;
  localparam int ADDR_W   = 11;
  localparam int NUM_USER = 16;
  localparam int USER_W   = 4;
  localparam int LEN_W    = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rdState_t;

  function automatic logic [DATA_W-1:0] getLane(
    input logic [DATA_W*NUM_USER-1:0] bus,
    input logic [USER_W-1:0]          sel
  );
    return bus[sel*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/derm_inbuf_out_fifo.sv
// rtl/derm_inbuf_out_fifo.sv - small output FIFO with flush; head word read straight from storage
module derm_inbuf_out_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 36,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign doPop   = pop && !empty;
  // a push into a full FIFO is fine when the head leaves on the same edge
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/derm_inbuf_read_ctrl.sv
// rtl/derm_inbuf_read_ctrl.sv - issues wrapping read runs to the buffer bank and streams one user lane out
module derm_inbuf_read_ctrl
  import derm_inbuf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_start,
  input  logic [USER_W-1:0]          i_user_sel,
  input  logic [ADDR_W-1:0]          i_start_addr,
  input  logic [LEN_W-1:0]           i_length,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [ADDR_W-1:0]          o_rd_addr,
  input  logic [DATA_W*NUM_USER-1:0] i_rd_data,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       i_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  rdState_t          state;
  rdState_t          stateNext;
  logic [USER_W-1:0] userSel;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic [CNT_W-1:0]  fifoCount;
  logic [CNT_W-1:0]  occupancy;
  logic              fifoEmpty;
  logic              fifoPop;
  logic              fifoPush;
  logic              rdIssue;
  logic              startRun;

  // a word in flight already owns a FIFO slot, so it counts toward occupancy
  assign occupancy = fifoCount + CNT_W'(inflight);
  assign rdIssue   = (state == READ) && (remaining != '0) &&
                     (occupancy < CNT_W'(FIFO_DEPTH)) && !i_abort;
  assign startRun  = (state == IDLE) && i_start && (i_length != '0) && !i_abort;
  assign fifoPush  = inflight && !i_abort;
  assign fifoPop   = o_valid && i_ready;

  assign o_valid = !fifoEmpty;
  assign o_busy  = (state == READ) || (state == DRAIN);
  assign o_done  = (state == DONE);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (i_start) stateNext = (i_length != '0) ? READ : DONE;
      READ:  if (remaining == '0) stateNext = DRAIN;
      DRAIN: if (!inflight && (fifoCount == '0 ||
                               (fifoCount == CNT_W'(1) && fifoPop)))
               stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (i_abort) stateNext = IDLE;
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state     <= IDLE;
      userSel   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      o_rd_addr <= '0;
    end else begin
      state    <= stateNext;
      inflight <= rdIssue;
      if (startRun) begin
        userSel   <= i_user_sel;
        remaining <= i_length;
        o_rd_addr <= i_start_addr;
      end else if (rdIssue) begin
        remaining <= remaining - 1'b1;
        o_rd_addr <= o_rd_addr + 1'b1;
      end
    end
  end

  derm_inbuf_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_outFifo (
    .clk      (i_core_clk),
    .rstn     (i_rx_rstn),
    .flush    (i_abort),
    .push     (fifoPush),
    .pushData (getLane(i_rd_data, userSel)),
    .pop      (fifoPop),
    .popData  (o_data),
    .count    (fifoCount),
    .empty    (fifoEmpty)
  );

endmodule

// File: tb/tb_derm_inbuf_read_ctrl.sv
// tb/tb_derm_inbuf_read_ctrl.sv - directed bench for the input buffer read controller
module tb_derm_inbuf_read_ctrl;

  logic          i_core_clk;
  logic          i_rx_rstn;
  logic          i_start;
  logic [3:0]    i_user_sel;
  logic [10:0]   i_start_addr;
  logic [11:0]   i_length;
  logic          i_abort;
  logic          o_busy;
  logic          o_done;
  logic [10:0]   o_rd_addr;
  logic [575:0]  i_rd_data;
  logic [35:0]   o_data;
  logic          o_valid;
  logic          i_ready;

  int vecCnt = 0;
  int errCnt = 0;
  logic fillOthers = 1'b0;

  logic [35:0] gotQ[$];
  logic [10:0] addrQ[$];
  int firstValid, lastPop, doneCyc, stallBad, maxAhead;
  logic [10:0] curStart;

  derm_inbuf_read_ctrl dut (
    .i_core_clk   (i_core_clk),
    .i_rx_rstn    (i_rx_rstn),
    .i_start      (i_start),
    .i_user_sel   (i_user_sel),
    .i_start_addr (i_start_addr),
    .i_length     (i_length),
    .i_abort      (i_abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  initial i_core_clk = 1'b0;
  always #5 i_core_clk = ~i_core_clk;

  function automatic logic [35:0] expWord(input int lane, input int addr);
    return (36'(lane) << 24) | 36'(32'hA00 + addr);
  endfunction

  // one-cycle-latency buffer bank model
  always @(posedge i_core_clk)
    for (int k = 0; k < 16; k++)
      i_rd_data[k*36 +: 36] <= (fillOthers && k != 15) ? 36'hFFFFFFFFF : expWord(k, int'(o_rd_addr));

  task automatic doStart(input logic [3:0] sel, input logic [10:0] addr, input logic [11:0] len);
    i_user_sel = sel; i_start_addr = addr; i_length = len; i_start = 1'b1; curStart = addr;
    @(negedge i_core_clk);
    i_start = 1'b0;
  endtask

  task automatic runCycles(input int maxCyc, input int readyPat);
    logic [10:0] diff;
    int ahead;
    logic prevStall;
    logic [35:0] prevData;
    gotQ.delete(); addrQ.delete();
    firstValid = -1; lastPop = -1; doneCyc = -1; stallBad = 0; maxAhead = 0;
    prevStall = 1'b0; prevData = '0;
    for (int c = 1; c <= maxCyc; c++) begin
      i_ready = (readyPat == 0) ? 1'b1 : (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3));
      addrQ.push_back(o_rd_addr);
      diff = o_rd_addr - curStart;
      ahead = int'(diff) - gotQ.size();
      if (ahead > maxAhead) maxAhead = ahead;
      if (prevStall && (o_data !== prevData || o_valid !== 1'b1)) stallBad++;
      prevStall = o_valid && !i_ready;
      prevData = o_data;
      if (o_valid && firstValid < 0) firstValid = c;
      if (o_valid && i_ready) begin gotQ.push_back(o_data); lastPop = c; end
      if (o_done) begin doneCyc = c; break; end
      @(negedge i_core_clk);
    end
  endtask

  task automatic test_reset;
    @(negedge i_core_clk);
    vecCnt++;
    if ({o_busy, o_done, o_valid, o_rd_addr, o_data} !== '0) begin
      errCnt++; $display("FAIL reset_outputs: got %0h expected 0", {o_busy, o_done, o_valid, o_rd_addr, o_data});
    end
    i_rx_rstn = 1'b1;
    @(negedge i_core_clk);
  endtask

  task automatic test_basic;
    doStart(4'd0, 11'd0, 12'd4);
    runCycles(40, 0);
    for (int i = 0; i < 4; i++) begin
      vecCnt++;
      if (addrQ[i] !== 11'(i)) begin errCnt++; $display("FAIL basic_addr%0d: got %0d expected %0d", i, addrQ[i], i); end
      vecCnt++;
      if ((i < gotQ.size() ? gotQ[i] : 36'hx) !== expWord(0, i)) begin
        errCnt++; $display("FAIL basic_data%0d: got %0h expected %0h", i, (i < gotQ.size() ? gotQ[i] : 36'hx), expWord(0, i));
      end
    end
    vecCnt++;
    if (firstValid != 3) begin errCnt++; $display("FAIL basic_first_valid: got %0d expected 3", firstValid); end
    vecCnt++;
    if (lastPop != 6 || doneCyc != 7) begin errCnt++; $display("FAIL basic_done: got pop %0d done %0d expected 6 7", lastPop, doneCyc); end
    @(negedge i_core_clk);
    vecCnt++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin errCnt++; $display("FAIL basic_done_pulse: got done %b busy %b expected 0 0", o_done, o_busy); end
  endtask

  task automatic test_wrap_lane;
    int expAddr;
    fillOthers = 1'b1;
    doStart(4'd15, 11'd2046, 12'd4);
    runCycles(40, 0);
    for (int i = 0; i < 4; i++) begin
      expAddr = (2046 + i) % 2048;
      vecCnt++;
      if (addrQ[i] !== 11'(expAddr)) begin errCnt++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, addrQ[i], expAddr); end
      vecCnt++;
      if ((i < gotQ.size() ? gotQ[i] : 36'hx) !== expWord(15, expAddr)) begin
        errCnt++; $display("FAIL wrap_data%0d: got %0h expected %0h", i, (i < gotQ.size() ? gotQ[i] : 36'hx), expWord(15, expAddr));
      end
    end
    vecCnt++;
    if (doneCyc != 7) begin errCnt++; $display("FAIL wrap_done: got %0d expected 7", doneCyc); end
    fillOthers = 1'b0;
    @(negedge i_core_clk);
  endtask

  task automatic test_backpressure;
    doStart(4'd7, 11'd0, 12'd16);
    runCycles(200, 1);
    vecCnt++;
    if (gotQ.size() != 16) begin errCnt++; $display("FAIL bp_count: got %0d expected 16", gotQ.size()); end
    for (int i = 0; i < 16; i++) begin
      vecCnt++;
      if ((i < gotQ.size() ? gotQ[i] : 36'hx) !== expWord(7, i)) begin
        errCnt++; $display("FAIL bp_data%0d: got %0h expected %0h", i, (i < gotQ.size() ? gotQ[i] : 36'hx), expWord(7, i));
      end
    end
    vecCnt++;
    if (stallBad != 0) begin errCnt++; $display("FAIL bp_stall_stable: got %0d changes expected 0", stallBad); end
    vecCnt++;
    if (maxAhead != 4) begin errCnt++; $display("FAIL bp_read_ahead: got %0d expected 4", maxAhead); end
    vecCnt++;
    if (doneCyc < 0 || doneCyc != lastPop + 1) begin errCnt++; $display("FAIL bp_done: got %0d expected %0d", doneCyc, lastPop + 1); end
    @(negedge i_core_clk);
  endtask

  task automatic test_zero_len;
    doStart(4'd1, 11'd700, 12'd0);
    runCycles(10, 0);
    vecCnt++;
    if (doneCyc != 1) begin errCnt++; $display("FAIL zero_done: got %0d expected 1", doneCyc); end
    vecCnt++;
    if (firstValid != -1) begin errCnt++; $display("FAIL zero_valid: got cycle %0d expected none", firstValid); end
    vecCnt++;
    if (o_rd_addr !== 11'd16) begin errCnt++; $display("FAIL zero_addr: got %0d expected 16", o_rd_addr); end
    @(negedge i_core_clk);
  endtask

  task automatic test_full_len;
    int expAddr;
    int bad;
    doStart(4'd3, 11'd5, 12'd2048);
    runCycles(2200, 0);
    vecCnt++;
    if (gotQ.size() != 2048) begin errCnt++; $display("FAIL full_count: got %0d expected 2048", gotQ.size()); end
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      expAddr = (5 + i) % 2048;
      vecCnt++;
      if ((i < gotQ.size() ? gotQ[i] : 36'hx) !== expWord(3, expAddr) && bad < 4) begin
        bad++; errCnt++; $display("FAIL full_data%0d: got %0h expected %0h", i, (i < gotQ.size() ? gotQ[i] : 36'hx), expWord(3, expAddr));
      end else if ((i < gotQ.size() ? gotQ[i] : 36'hx) !== expWord(3, expAddr)) errCnt++;
    end
    vecCnt++;
    if (doneCyc != 2051) begin errCnt++; $display("FAIL full_done: got %0d expected 2051", doneCyc); end
    @(negedge i_core_clk);
  endtask

  task automatic test_abort;
    int doneSeen;
    i_ready = 1'b0;
    doStart(4'd2, 11'd0, 12'd8);
    @(negedge i_core_clk);
    i_user_sel = 4'd9; i_start_addr = 11'd500; i_length = 12'd3; i_start = 1'b1;
    @(negedge i_core_clk);
    i_start = 1'b0;
    vecCnt++;
    if (o_rd_addr !== 11'd2) begin errCnt++; $display("FAIL abort_busy_start_ignored: got %0d expected 2", o_rd_addr); end
    @(negedge i_core_clk);
    vecCnt++;
    if (o_valid !== 1'b1 || o_data !== expWord(2, 0)) begin
      errCnt++; $display("FAIL abort_pre_head: got %b %0h expected 1 %0h", o_valid, o_data, expWord(2, 0));
    end
    i_abort = 1'b1;
    @(negedge i_core_clk);
    i_abort = 1'b0;
    vecCnt++;
    if ({o_valid, o_busy, o_done} !== 3'b000) begin errCnt++; $display("FAIL abort_outputs: got %b expected 000", {o_valid, o_busy, o_done}); end
    doneSeen = 0;
    i_user_sel = 4'd4; i_start_addr = 11'd900; i_length = 12'd5; i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_core_clk);
    i_start = 1'b0; i_abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (o_done || o_busy || o_valid) doneSeen++;
      @(negedge i_core_clk);
    end
    vecCnt++;
    if (doneSeen != 0 || o_rd_addr !== 11'd3) begin
      errCnt++; $display("FAIL abort_quiet: got %0d active cycles addr %0d expected 0 3", doneSeen, o_rd_addr);
    end
    doStart(4'd2, 11'd100, 12'd2);
    runCycles(40, 0);
    vecCnt++;
    if (gotQ.size() != 2 || gotQ[0] !== expWord(2, 100) || gotQ[1] !== expWord(2, 101)) begin
      errCnt++; $display("FAIL abort_restart: got %0d words first %0h expected 2 words first %0h", gotQ.size(), (gotQ.size() > 0 ? gotQ[0] : 36'hx), expWord(2, 100));
    end
    vecCnt++;
    if (doneCyc != 5) begin errCnt++; $display("FAIL abort_restart_done: got %0d expected 5", doneCyc); end
    @(negedge i_core_clk);
  endtask

  task automatic test_async_reset;
    i_ready = 1'b0;
    doStart(4'd1, 11'd10, 12'd8);
    repeat (3) @(negedge i_core_clk);
    vecCnt++;
    if ({o_busy, o_valid, o_rd_addr} !== {2'b11, 11'd13}) begin
      errCnt++; $display("FAIL rst_pre_state: got %0h expected %0h", {o_busy, o_valid, o_rd_addr}, {2'b11, 11'd13});
    end
    #2;
    i_rx_rstn = 1'b0;
    #1;
    vecCnt++;
    if ({o_busy, o_done, o_valid, o_rd_addr, o_data} !== '0) begin
      errCnt++; $display("FAIL rst_async_outputs: got %0h expected 0", {o_busy, o_done, o_valid, o_rd_addr, o_data});
    end
    @(negedge i_core_clk);
    i_rx_rstn = 1'b1;
    @(negedge i_core_clk);
    vecCnt++;
    if ({o_busy, o_valid} !== 2'b00) begin errCnt++; $display("FAIL rst_idle: got %b expected 00", {o_busy, o_valid}); end
    doStart(4'd1, 11'd10, 12'd3);
    runCycles(40, 0);
    vecCnt++;
    if (gotQ.size() != 3 || gotQ[0] !== expWord(1, 10) || gotQ[2] !== expWord(1, 12)) begin
      errCnt++; $display("FAIL rst_restart: got %0d words first %0h expected 3 words first %0h", gotQ.size(), (gotQ.size() > 0 ? gotQ[0] : 36'hx), expWord(1, 10));
    end
    vecCnt++;
    if (doneCyc != 6) begin errCnt++; $display("FAIL rst_restart_done: got %0d expected 6", doneCyc); end
  endtask

  initial begin
    i_rx_rstn = 1'b0; i_start = 1'b0; i_user_sel = '0; i_start_addr = '0;
    i_length = '0; i_abort = 1'b0; i_ready = 1'b1; curStart = '0;
    test_reset();
    test_basic();
    test_wrap_lane();
    test_backpressure();
    test_zero_len();
    test_full_len();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end

endmodule
